aes_key_expand: RTL and testbench
=================================

AES_KEY_EXPAND -- requirements
Module: aes_key_expand

Interface
REQ-001 SHALL have parameter MAX_RK, default 15, meaning the number of 128-bit round-key slots in key_words.
REQ-002 SHALL have port eph1, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port start, input, 1 bit: request to expand a new key.
REQ-005 SHALL have port key, input, 256 bits: cipher key, left-justified (128-bit keys in [255:128], 192-bit keys in [255:64]); unused low bits are ignored.
REQ-006 SHALL have port key_size, input, 2 bits: 00 = 128-bit key, 01 = 192-bit key, 1x = 256-bit key.
REQ-007 SHALL have port key_words, output, [MAX_RK:1][127:0]: expanded round keys; slot 15 holds round key 0.
REQ-008 SHALL have port ready, output, 1 bit: level-high while key_words is complete and valid; feeds the ready input of aes_build.

Function
REQ-009 SHALL use Nk = 4/6/8 and Nw = 44/52/60 words for key sizes 128/192/256.
REQ-010 SHALL store word w[i] in key_words[15 - i/4], bits [127-32*(i%4) -: 32].
REQ-011 SHALL implement FSM states IDLE, EXPAND, DONE.
REQ-012 SHALL, in IDLE or DONE with start=1, on that edge latch key_size, write w[0..Nk-1] from key, zero all other slots, deassert ready, and enter EXPAND.
REQ-013 SHALL compute exactly one word per cycle in EXPAND: temp=w[i-1]; if i%Nk==0 then temp=SubWord(RotWord(temp))^Rcon[i/Nk]; else if Nk==8 and i%8==4 then temp=SubWord(temp); w[i]=w[i-Nk]^temp.
REQ-014 SHALL generate Rcon iteratively (01,02,04,...,80,1B,36) by GF(2^8) doubling, without a lookup table.
REQ-015 SHALL write w[Nw-1], assert ready, and enter DONE on the same edge; ready is first visible 40/46/52 cycles after the start-sampling edge.
REQ-016 SHALL ignore start, key, and key_size while in EXPAND.
REQ-017 SHALL hold key_words and ready stable in DONE until the next accepted start.
REQ-018 SHALL keep slots beyond round key Nr at zero (slots 4:1 for 128-bit keys, slots 2:1 for 192-bit keys).

Reset
REQ-019 SHALL, on reset_n=0, immediately clear the FSM to IDLE, key_words to all zeros, ready to 0, and the Rcon and word counters, including when asserted mid-EXPAND.
REQ-020 SHALL accept start on the first edge after reset_n deasserts.

Configuration
REQ-021 SHALL, when AES_KEXP_BUSY_EN is defined, add output busy (1 bit), high exactly while in EXPAND and reset to 0; without the macro the port and its logic SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-022 SHALL take key-size encodings, the Nk/Nw constants, the FSM state enum, and the Rcon seed from the shared AES package used with aeslib.
REQ-023 SHALL instantiate one combinational sub-module, aes_subword, performing a 4-byte S-box substitution, and SHALL share that single instance between the RotWord and 256-bit paths.
REQ-024 SHALL hold a sliding window of the last Nk words in a rolling register so that w[i-Nk] is read without a wide mux over key_words.

Verification
REQ-025 SHALL verify the 128-bit case: key 2b7e151628aed2a6abf7158809cf4f3c -> key_words[14][127:96]=a0fafe17, key_words[5]=d014f9a8c9ee2589e13f0cc8b6630ca6, ready high 40 cycles after start, slots 4:1 zero.
REQ-026 SHALL verify the 192-bit case: key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> key_words[3]=e98ba06f448c773c8ecc720401002202, ready high after 46 cycles.
REQ-027 SHALL verify the 256-bit case: key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> key_words[1]=fe4890d1e6188d0b046df344706c631e, ready high after 52 cycles.
REQ-028 SHALL verify start pulsed and key_size changed at cycle 10 of EXPAND -> both ignored, and the result equals the undisturbed run.
REQ-029 SHALL verify reset_n pulsed low mid-EXPAND -> key_words all zero and ready=0 immediately; then a new 128-bit start -> correct result after 40 cycles.
REQ-030 SHALL verify start in DONE with a different key -> ready drops on the next edge and the new result appears with the correct latency; with AES_KEXP_BUSY_EN defined, busy high for exactly Nw-Nk cycles.

Source files
------------

// File: rtl/aes_key_expand_pkg.sv
// Shared AES definitions: key-size encodings, Nk/Nw constants, key-expansion FSM states,
// Rcon seed and GF(2^8) doubling.
package aes_key_expand_pkg;

  typedef enum logic [1:0] {
    KS_128 = 2'b00,
    KS_192 = 2'b01,
    KS_256 = 2'b10
  } key_size_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_DONE   = 2'd2
  } kexp_state_e;

  localparam int NK_128 = 4;
  localparam int NK_192 = 6;
  localparam int NK_256 = 8;
  localparam int NW_128 = 44;
  localparam int NW_192 = 52;
  localparam int NW_256 = 60;

  localparam logic [7:0] RCON_SEED = 8'h01;

  // 2'b11 is also a 256-bit key, so fold it onto KS_256
  function automatic key_size_e norm_key_size(input logic [1:0] ks);
    return ks[1] ? KS_256 : (ks[0] ? KS_192 : KS_128);
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_subword.sv
// Combinational 4-byte AES S-box substitution; each S-box is computed as the
// GF(2^8) inverse (x^254) followed by the affine transform, so no table is stored.
module aes_subword
  import aes_key_expand_pkg::*;
(
  input  logic [31:0] i_word,
  output logic [31:0] o_word
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = b;
    inv = 8'h01;
    // x^254 = x^(2+4+...+128); zero maps to zero as required
    for (int k = 0; k < 7; k++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  assign o_word = {sbox(i_word[31:24]), sbox(i_word[23:16]),
                   sbox(i_word[15:8]),  sbox(i_word[7:0])};

endmodule

// File: rtl/aes_key_expand.sv
// AES key expansion, one word per clock, for 128/192/256-bit keys.
// Optional busy output enabled by defining AES_KEXP_BUSY_EN.
//
//   state     | meaning
//   ST_IDLE   | no key loaded, waiting for start
//   ST_EXPAND | generating w[Nk..Nw-1], inputs ignored
//   ST_DONE   | key_words complete, ready high, start restarts
module aes_key_expand
  import aes_key_expand_pkg::*;
#(
  parameter int MAX_RK = 15
) (
  input  logic                     eph1,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic [255:0]             key,
  input  logic [1:0]               key_size,
  output logic [MAX_RK:1][127:0]   key_words,
  output logic                     ready
`ifdef AES_KEXP_BUSY_EN
  ,
  output logic                     busy
`endif
);

  kexp_state_e              r_state;
  key_size_e                r_ks;
  logic [5:0]               r_idx;
  logic [2:0]               r_phase;
  logic [7:0]               r_rcon;
  logic [7:0][31:0]         r_win;
  logic [MAX_RK:1][127:0]   r_kw;
  logic                     r_ready;

  key_size_e                w_ks_in;
  logic [5:0]               w_nk_in;
  logic [7:0][31:0]         w_load;
  logic [127:0]             w_kw_lo;
  logic [2:0]               w_nk_m1;
  logic [5:0]               w_nw_m1;
  logic [31:0]              w_prev;
  logic [31:0]              w_old;
  logic [31:0]              w_sub_in;
  logic [31:0]              w_sub_out;
  logic [31:0]              w_temp;
  logic [31:0]              w_new;
  logic [3:0]               w_slot;

  assign w_ks_in = norm_key_size(key_size);

  // Window index 7 is w[i-1]; the cipher key is loaded so that w[i-Nk] sits at 8-Nk
  always_comb begin
    w_load  = '0;
    w_nk_in = 6'(NK_256);
    w_kw_lo = key[127:0];
    case (w_ks_in)
      KS_128: begin
        for (int k = 0; k < 4; k++) w_load[4+k] = key[255-32*k -: 32];
        w_nk_in = 6'(NK_128);
        w_kw_lo = '0;
      end
      KS_192: begin
        for (int k = 0; k < 6; k++) w_load[2+k] = key[255-32*k -: 32];
        w_nk_in = 6'(NK_192);
        w_kw_lo = {key[127:64], 64'h0};
      end
      default: begin
        for (int k = 0; k < 8; k++) w_load[k] = key[255-32*k -: 32];
      end
    endcase
  end

  always_comb begin
    w_nk_m1 = 3'(NK_256 - 1);
    w_nw_m1 = 6'(NW_256 - 1);
    w_old   = r_win[0];
    case (r_ks)
      KS_128: begin
        w_nk_m1 = 3'(NK_128 - 1);
        w_nw_m1 = 6'(NW_128 - 1);
        w_old   = r_win[4];
      end
      KS_192: begin
        w_nk_m1 = 3'(NK_192 - 1);
        w_nw_m1 = 6'(NW_192 - 1);
        w_old   = r_win[2];
      end
      default: ;
    endcase
  end

  assign w_prev   = r_win[7];
  assign w_sub_in = (r_phase == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;

  aes_subword u_subword (
    .i_word (w_sub_in),
    .o_word (w_sub_out)
  );

  always_comb begin
    w_temp = w_prev;
    if (r_phase == 3'd0)
      w_temp = w_sub_out ^ {r_rcon, 24'h0};
    else if (r_ks == KS_256 && r_phase == 3'd4)
      w_temp = w_sub_out;
  end

  assign w_new  = w_old ^ w_temp;
  assign w_slot = 4'(MAX_RK) - r_idx[5:2];

  always_ff @(posedge eph1 or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_ks    <= KS_128;
      r_idx   <= '0;
      r_phase <= '0;
      r_rcon  <= '0;
      r_win   <= '0;
      r_kw    <= '0;
      r_ready <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_state            <= ST_EXPAND;
            r_ks               <= w_ks_in;
            r_idx              <= w_nk_in;
            r_phase            <= '0;
            r_rcon             <= RCON_SEED;
            r_win              <= w_load;
            r_kw               <= '0;
            r_kw[MAX_RK]       <= key[255:128];
            r_kw[MAX_RK-1]     <= w_kw_lo;
            r_ready            <= 1'b0;
          end
        end
        ST_EXPAND: begin
          r_kw[w_slot][{~r_idx[1:0], 5'b0} +: 32] <= w_new;
          r_win   <= {w_new, r_win[7:1]};
          r_idx   <= r_idx + 6'd1;
          r_phase <= (r_phase == w_nk_m1) ? 3'd0 : r_phase + 3'd1;
          if (r_phase == 3'd0) r_rcon <= xtime(r_rcon);
          if (r_idx == w_nw_m1) begin
            r_state <= ST_DONE;
            r_ready <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign key_words = r_kw;
  assign ready     = r_ready;

`ifdef AES_KEXP_BUSY_EN
  assign busy = (r_state == ST_EXPAND);
`endif

endmodule

// File: tb/tb_aes_key_expand.sv
// Directed bench for aes_key_expand using the FIPS-197 key-expansion vectors.
// Also covers the busy output when built with AES_KEXP_BUSY_EN.
module tb_aes_key_expand;

  logic                 eph1 = 1'b0;
  logic                 reset_n = 1'b0;
  logic                 start = 1'b0;
  logic [255:0]         key = '0;
  logic [1:0]           key_size = 2'b00;
  logic [15:1][127:0]   key_words;
  logic                 ready;
`ifdef AES_KEXP_BUSY_EN
  logic                 busy;
`endif

  int vecs = 0;
  int errs = 0;
  int bcnt = 0;

  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] K256 =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  always #5 eph1 = ~eph1;

  aes_key_expand #(.MAX_RK(15)) dut (
    .eph1      (eph1),
    .reset_n   (reset_n),
    .start     (start),
    .key       (key),
    .key_size  (key_size),
    .key_words (key_words),
    .ready     (ready)
`ifdef AES_KEXP_BUSY_EN
    ,
    .busy      (busy)
`endif
  );

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [255:0] k, input logic [1:0] ks, input string tag);
    @(negedge eph1);
    key      = k;
    key_size = ks;
    start    = 1'b1;
    @(posedge eph1);
    #1;
    chk({tag, "_rdy_drop"}, 512'(ready), 512'(0));
`ifdef AES_KEXP_BUSY_EN
    chk({tag, "_busy_on"}, 512'(busy), 512'(1));
    bcnt = busy ? 1 : 0;
`endif
    @(negedge eph1);
    start = 1'b0;
  endtask

  task automatic wait_lat(input int exp_lat, input int nw_nk, input int disturb_at,
                          input string tag);
    int n;
    n = 0;
    do begin
      @(posedge eph1);
      #1;
      n++;
`ifdef AES_KEXP_BUSY_EN
      if (busy) bcnt++;
`endif
      if (n == disturb_at) begin
        start    = 1'b1;
        key_size = 2'b00;
        key      = ~K192;
      end else if (n == disturb_at + 1) begin
        start = 1'b0;
      end
    end while (!ready && n < 200);
    chk({tag, "_latency"}, 512'(n), 512'(exp_lat));
`ifdef AES_KEXP_BUSY_EN
    chk({tag, "_busy_cycles"}, 512'(bcnt), 512'(nw_nk));
`else
    if (nw_nk < 0) $display("unexpected Nw-Nk %0d", nw_nk);
`endif
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_kw_zero", 512'(|key_words), 512'(0));
    chk("rst_ready", 512'(ready), 512'(0));
`ifdef AES_KEXP_BUSY_EN
    chk("rst_busy", 512'(busy), 512'(0));
`endif
    @(negedge eph1);
    reset_n = 1'b1;

    // 128-bit key
    do_start(K128, 2'b00, "k128");
    wait_lat(40, 40, -1, "k128");
    chk("k128_slot15", 512'(key_words[15]), 512'(128'h2b7e151628aed2a6abf7158809cf4f3c));
    chk("k128_w4", 512'(key_words[14][127:96]), 512'(32'ha0fafe17));
    chk("k128_slot5", 512'(key_words[5]), 512'(128'hd014f9a8c9ee2589e13f0cc8b6630ca6));
    chk("k128_slots4to1", 512'(key_words[4:1]), 512'(0));
    repeat (5) @(posedge eph1);
    #1;
    chk("k128_hold_ready", 512'(ready), 512'(1));
    chk("k128_hold_slot5", 512'(key_words[5]), 512'(128'hd014f9a8c9ee2589e13f0cc8b6630ca6));

    // 192-bit key started from DONE
    do_start(K192, 2'b01, "k192");
    wait_lat(46, 46, -1, "k192");
    chk("k192_slot15", 512'(key_words[15]), 512'(128'h8e73b0f7da0e6452c810f32b809079e5));
    chk("k192_w4w5", 512'(key_words[14][127:64]), 512'(64'h62f8ead2522c6b7b));
    chk("k192_slot3", 512'(key_words[3]), 512'(128'he98ba06f448c773c8ecc720401002202));
    chk("k192_slots2to1", 512'(key_words[2:1]), 512'(0));

    // 256-bit key, using the 2'b11 encoding
    do_start(K256, 2'b11, "k256");
    wait_lat(52, 52, -1, "k256");
    chk("k256_slot15", 512'(key_words[15]), 512'(128'h603deb1015ca71be2b73aef0857d7781));
    chk("k256_slot14", 512'(key_words[14]), 512'(128'h1f352c073b6108d72d9810a30914dff4));
    chk("k256_slot1", 512'(key_words[1]), 512'(128'hfe4890d1e6188d0b046df344706c631e));

    // start/key/key_size disturbed during EXPAND must be ignored
    do_start(K192, 2'b01, "dist");
    wait_lat(46, 46, 10, "dist");
    chk("dist_slot15", 512'(key_words[15]), 512'(128'h8e73b0f7da0e6452c810f32b809079e5));
    chk("dist_slot3", 512'(key_words[3]), 512'(128'he98ba06f448c773c8ecc720401002202));
    chk("dist_slots2to1", 512'(key_words[2:1]), 512'(0));

    // Reset mid-EXPAND, then restart on the first edge after release
    do_start(K256, 2'b10, "abort");
    repeat (15) @(posedge eph1);
    #1;
    reset_n = 1'b0;
    #1;
    chk("abort_kw_zero", 512'(|key_words), 512'(0));
    chk("abort_ready", 512'(ready), 512'(0));
`ifdef AES_KEXP_BUSY_EN
    chk("abort_busy", 512'(busy), 512'(0));
`endif
    @(posedge eph1);
    #2;
    reset_n = 1'b1;
    do_start(K128, 2'b00, "rerun");
    wait_lat(40, 40, -1, "rerun");
    chk("rerun_w4", 512'(key_words[14][127:96]), 512'(32'ha0fafe17));
    chk("rerun_slot5", 512'(key_words[5]), 512'(128'hd014f9a8c9ee2589e13f0cc8b6630ca6));
    chk("rerun_slots4to1", 512'(key_words[4:1]), 512'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
